// File: rtl/card_pkg.sv
// Shared types and constants for the card dealer: FSM states, rank encoding,
// shoe geometry and the LFSR step used by the random source.
package card_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RESHUFFLE,
      DRAW
   } state_t;

   typedef logic [3:0] rank_t;

   localparam int unsigned RANK_MIN       = 1;
   localparam int unsigned RANK_MAX       = 13;
   localparam int unsigned CARDS_PER_DECK = 52;

   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; advances every cycle unless reset or loaded.
// The caller guarantees load_val is never zero.
module lfsr16
   import card_pkg::*;
#(
   parameter logic [15:0] RESET_VAL = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= RESET_VAL;
      else if (load)
         q <= load_val;
      else
         q <= lfsr_next(q);
   end

endmodule

// File: rtl/card_dealer.sv
// Deals random ranks 1..13 from a finite shoe of DECKS x 52 cards, with a
// bounded number of random tries before a lowest-available-rank fallback.
module card_dealer
   import card_pkg::*;
#(
   parameter int unsigned DECKS     = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int unsigned MAX_TRIES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_load,
   input  logic [15:0] seed,
   input  logic        deal_req,
   output logic        busy,
   output logic        out_valid,
   output rank_t       card,
   output logic [7:0]  cards_left,
   output logic        reshuffled
);

   localparam logic [4:0]  FULL_RANK = 5'(4 * DECKS);
   localparam logic [7:0]  FULL_SHOE = 8'(CARDS_PER_DECK * DECKS);
   localparam int unsigned TW        = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

   state_t        state;
   logic [TW-1:0] tries;
   logic [4:0]    cnt      [16];
   logic [4:0]    full_cnt [16];

   logic [15:0]   lfsr_q;
   logic [15:0]   seed_eff;
   logic [11:0]   lfsr_unused;
   rank_t         cand;
   logic          cand_ok;
   rank_t         fb_rank;
   rank_t         draw_rank;
   logic          draw_done;
   logic          dec_en;

   assign seed_eff    = (seed == '0) ? LFSR_SEED : seed;
   assign lfsr_unused = lfsr_q[15:4];

   lfsr16 #(
      .RESET_VAL(LFSR_SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (seed_load),
      .load_val (seed_eff),
      .q        (lfsr_q)
   );

   always_comb begin
      for (int unsigned r = 0; r < 16; r++)
         full_cnt[r] = (r >= RANK_MIN && r <= RANK_MAX) ? FULL_RANK : '0;
   end

   // Lowest non-empty rank, used when the random tries are exhausted
   always_comb begin
      fb_rank = '0;
      for (int unsigned r = RANK_MAX; r >= RANK_MIN; r--)
         if (cnt[4'(r)] != '0)
            fb_rank = rank_t'(r);
   end

   always_comb begin
      cand      = lfsr_q[3:0];
      cand_ok   = (cand >= rank_t'(RANK_MIN)) && (cand <= rank_t'(RANK_MAX)) &&
                  (cnt[cand] != '0);
      draw_rank = cand_ok ? cand : fb_rank;
      draw_done = cand_ok || (tries == LAST_TRY);
      dec_en    = (state == DRAW) && draw_done && !rst && !seed_load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         card       <= '0;
         reshuffled <= 1'b0;
         tries      <= '0;
         cards_left <= FULL_SHOE;
         cnt        <= full_cnt;
      end else begin
         out_valid  <= 1'b0;
         reshuffled <= 1'b0;
         if (seed_load) begin
            state      <= IDLE;
            busy       <= 1'b0;
            tries      <= '0;
            cards_left <= FULL_SHOE;
            cnt        <= full_cnt;
         end else begin
            case (state)
               IDLE: begin
                  if (deal_req) begin
                     busy  <= 1'b1;
                     tries <= '0;
                     if (cards_left == '0) begin
                        state      <= RESHUFFLE;
                        reshuffled <= 1'b1;
                     end else begin
                        state <= DRAW;
                     end
                  end
               end
               RESHUFFLE: begin
                  cards_left <= FULL_SHOE;
                  cnt        <= full_cnt;
                  state      <= DRAW;
               end
               DRAW: begin
                  if (draw_done) begin
                     cnt[draw_rank] <= cnt[draw_rank] - 5'd1;
                     cards_left     <= cards_left - 8'd1;
                     card           <= draw_rank;
                     out_valid      <= 1'b1;
                     busy           <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     tries <= tries + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      dec_en |-> (cnt[draw_rank] != '0) && (cards_left != '0));

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: LFSR/shoe reference model, scoreboard
// of expected cards and latencies, table-driven seeds plus corner sequences.
module tb_card_dealer;

   localparam int unsigned DECKS     = 1;
   localparam logic [15:0] SEED0     = 16'hACE1;
   localparam int unsigned MAX_TRIES = 8;

   logic        clk = 1'b0;
   logic        rst, seed_load, deal_req;
   logic [15:0] seed;
   logic        busy, out_valid, reshuffled;
   logic [3:0]  card;
   logic [7:0]  cards_left;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_lfsr;
   int          m_cnt [16];
   int          m_left;
   int          tally [16];

   typedef struct {
      logic [3:0] card;
      int         lat;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [15:0] seed;
      int          n;
      int          left;
   } vec_t;
   vec_t tbl [4];

   card_dealer #(
      .DECKS     (DECKS),
      .LFSR_SEED (SEED0),
      .MAX_TRIES (MAX_TRIES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (seed_load),
      .seed       (seed),
      .deal_req   (deal_req),
      .busy       (busy),
      .out_valid  (out_valid),
      .card       (card),
      .cards_left (cards_left),
      .reshuffled (reshuffled)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] adv(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

   always @(posedge clk) begin
      if (rst)
         m_lfsr <= SEED0;
      else if (seed_load)
         m_lfsr <= (seed == 16'h0) ? SEED0 : seed;
      else
         m_lfsr <= adv(m_lfsr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_full();
      for (int r = 0; r < 16; r++)
         m_cnt[r] = (r >= 1 && r <= 13) ? 4 * DECKS : 0;
      m_left = 52 * DECKS;
   endtask

   function automatic void predict(input logic [15:0] l0, output logic [3:0] c, output int t);
      logic [15:0] l;
      logic [3:0]  k;
      l = l0;
      for (int i = 0; i < MAX_TRIES; i++) begin
         k = l[3:0];
         if (k >= 1 && k <= 13 && m_cnt[k] > 0) begin
            c = k;
            t = i + 1;
            return;
         end
         l = adv(l);
      end
      c = 0;
      for (int r = 13; r >= 1; r--)
         if (m_cnt[r] > 0) c = 4'(r);
      t = MAX_TRIES;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1; seed_load = 0; deal_req = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      model_full();
   endtask

   task automatic load_seed(input logic [15:0] s);
      @(negedge clk);
      seed_load = 1; seed = s;
      @(negedge clk);
      seed_load = 0;
      model_full();
   endtask

   task automatic deal(input bit busy_pulse, output logic [3:0] got);
      logic [15:0] l0;
      logic [3:0]  c;
      int          t, n;
      bit          resh;
      exp_t        e;
      @(negedge clk);
      chk("idle_not_busy", busy, 0);
      deal_req = 1;
      @(negedge clk);
      deal_req = 0;
      n = 1;
      resh = (m_left == 0);
      if (resh) begin
         model_full();
         l0 = adv(m_lfsr);
      end else begin
         l0 = m_lfsr;
      end
      chk("reshuffled_pulse", reshuffled, resh);
      chk("busy_in_draw", busy, 1);
      predict(l0, c, t);
      m_cnt[c]--;
      m_left--;
      e.card = c;
      e.lat  = t + 1 + (resh ? 1 : 0);
      sb.push_back(e);
      if (busy_pulse) deal_req = 1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         deal_req = 0;
         n++;
      end
      deal_req = 0;
      e = sb.pop_front();
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL deal_timeout: no out_valid after %0d cycles, expected card %0d", n, e.card);
         got = 0;
      end else begin
         chk("card", card, e.card);
         chk("latency", n, e.lat);
         chk("cards_left", cards_left, m_left);
         got = card;
      end
   endtask

   task automatic count_valid(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [3:0] g;
      int         nv;
      int         rr;

      tbl[0] = '{seed: 16'h0001, n: 1, left: 51};
      tbl[1] = '{seed: 16'h0000, n: 3, left: 49};
      tbl[2] = '{seed: 16'hBEEF, n: 5, left: 47};
      tbl[3] = '{seed: 16'hFFFF, n: 2, left: 50};

      rst = 0; seed_load = 0; deal_req = 0; seed = 0;

      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_card", card, 0);
      chk("rst_cards_left", cards_left, 52);
      chk("rst_reshuffled", reshuffled, 0);

      foreach (tbl[i]) begin
         load_seed(tbl[i].seed);
         chk("tbl_full_after_seed", cards_left, 52);
         repeat (tbl[i].n) deal(0, g);
         chk("tbl_left", cards_left, tbl[i].left);
      end

      do_reset();
      for (int r = 0; r < 16; r++) tally[r] = 0;
      repeat (52) begin
         deal(0, g);
         tally[g]++;
      end
      for (int r = 1; r <= 13; r++) chk("rank_tally", tally[r], 4);
      chk("shoe_empty", cards_left, 0);
      deal(0, g);
      chk("after_reshuffle_left", cards_left, 51);

      load_seed(16'hBEEF);
      repeat (51) deal(0, g);
      rr = 0;
      for (int r = 13; r >= 1; r--) if (m_cnt[r] > 0) rr = r;
      deal(0, g);
      chk("last_card", g, rr);
      chk("last_card_left", cards_left, 0);

      load_seed(16'h1234);
      deal(1, g);
      count_valid(12, nv);
      chk("dropped_busy_req", nv, 0);

      @(negedge clk);
      seed_load = 1; seed = 16'h5555; deal_req = 1;
      @(negedge clk);
      seed_load = 0; deal_req = 0;
      model_full();
      chk("seedload_busy", busy, 0);
      count_valid(12, nv);
      chk("seedload_no_valid", nv, 0);
      chk("seedload_left", cards_left, 52);

      deal(0, g);
      @(negedge clk);
      deal_req = 1;
      @(negedge clk);
      deal_req = 0;
      chk("middraw_busy", busy, 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      model_full();
      chk("middraw_rst_valid", out_valid, 0);
      chk("middraw_rst_busy", busy, 0);
      chk("middraw_rst_card", card, 0);
      chk("middraw_rst_left", cards_left, 52);
      chk("middraw_rst_resh", reshuffled, 0);
      count_valid(10, nv);
      chk("middraw_no_valid", nv, 0);
      deal(0, g);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
